// File: rtl/muntjac_tl_ram_device.sv
// muntjac_tl_ram_device: TileLink TL-UH responder backed by a 64-bit-wide internal RAM
module muntjac_tl_ram_device #(
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned SinkWidth   = 1,
  parameter logic [55:0] BaseAddr    = 56'h80000000,
  parameter int unsigned Depth       = 4096,
  parameter int unsigned MaxSize     = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [3:0]             a_size,
  input  logic [SourceWidth-1:0] a_source,
  input  logic [55:0]            a_address,
  input  logic [7:0]             a_mask,
  input  logic [63:0]            a_data,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [2:0]             d_opcode,
  output logic [1:0]             d_param,
  output logic [3:0]             d_size,
  output logic [SourceWidth-1:0] d_source,
  output logic [SinkWidth-1:0]   d_sink,
  output logic                   d_denied,
  output logic                   d_corrupt,
  output logic [63:0]            d_data,
  output logic                   b_valid,
  output logic                   c_ready,
  output logic                   e_ready
);
  localparam int IW = $clog2(Depth);
  typedef enum logic [1:0] {IDLE, READ, WRITE, WACK} state_e;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d, bm1_q, a_bm1, dop_q;
  logic [IW-1:0] base_q, a_base, ram_idx;
  logic [SourceWidth-1:0] src_q;
  logic [3:0] size_q;
  logic den_q, cor_q;
  logic [63:0] mem [Depth];
  logic [63:0] rdata;
  logic [55:0] off;
  logic a_fire, d_fire, is_get, is_put, is_ari, a_den, we, re;
  logic unused;
  assign off     = a_address - BaseAddr;
  assign is_get  = a_opcode == 3'd4;
  assign is_put  = a_opcode <= 3'd1;
  assign is_ari  = a_opcode == 3'd2 || a_opcode == 3'd3;
  assign a_bm1   = !(is_get || is_put || is_ari) || a_size <= 4'd3 ? 3'd0 :
                   a_size >= 4'd6 ? 3'd7 : 3'((4'd1 << (a_size - 4'd3)) - 4'd1);
  assign a_base  = off[IW+2:3] & ~IW'(a_bm1);
  assign a_den   = a_address < BaseAddr || off[55:3] >= 53'(Depth) ||
                   a_size > 4'(MaxSize) || !(is_get || is_put);
  assign a_ready = rst_ni && (state_q == IDLE || state_q == WRITE);
  assign d_valid = state_q == READ || state_q == WACK;
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid && d_ready;
  assign d_opcode  = dop_q;
  assign d_param   = '0;
  assign d_size    = size_q;
  assign d_source  = src_q;
  assign d_sink    = '0;
  assign d_denied  = den_q;
  assign d_corrupt = cor_q;
  assign d_data    = state_q == READ && !den_q ? rdata : '0;
  assign b_valid   = 1'b0;
  assign c_ready   = 1'b1;
  assign e_ready   = 1'b1;
  assign unused    = ^{a_param, off[2:0]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    re      = 1'b0;
    ram_idx = base_q + IW'(cnt_q);
    case (state_q)
      IDLE: if (a_fire) begin
        ram_idx = a_base;
        we      = is_put && !a_den;
        re      = is_get;
        cnt_d   = !is_get && a_bm1 != 3'd0 ? 3'd1 : 3'd0;
        state_d = is_get ? READ : a_bm1 != 3'd0 ? WRITE : is_ari ? READ : WACK;
      end
      WRITE: if (a_fire) begin
        we      = dop_q == 3'd0 && !den_q;
        cnt_d   = cnt_q == bm1_q ? 3'd0 : cnt_q + 3'd1;
        state_d = cnt_q != bm1_q ? WRITE : dop_q == 3'd0 ? WACK : READ;
      end
      READ: if (d_fire) begin
        re      = cnt_q != bm1_q;
        ram_idx = base_q + IW'(cnt_q) + IW'(1);
        cnt_d   = cnt_q == bm1_q ? 3'd0 : cnt_q + 3'd1;
        state_d = cnt_q == bm1_q ? IDLE : READ;
      end
      WACK: if (d_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bm1_q   <= '0;
      base_q  <= '0;
      src_q   <= '0;
      size_q  <= '0;
      den_q   <= 1'b0;
      cor_q   <= 1'b0;
      dop_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && a_fire) begin
        bm1_q  <= a_bm1;
        base_q <= a_base;
        src_q  <= a_source;
        size_q <= a_size;
        den_q  <= a_den;
        cor_q  <= (is_get && a_den) || is_ari;
        dop_q  <= is_get || is_ari ? 3'd1 : is_put ? 3'd0 : 3'd2;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (we)
      for (int i = 0; i < 8; i++)
        if (a_mask[i]) mem[ram_idx][8*i +: 8] <= a_data[8*i +: 8];
    if (re) rdata <= mem[ram_idx];
  end
endmodule

// File: doc/muntjac_tl_ram_device.md
Name: muntjac_tl_ram_device

Overview:
- TileLink TL-UH responder (device end) backed by an internal 64-bit-wide RAM.
- Sits below the core's memory socket as a simulation and boot-RAM target.
- Accepts Get, PutFullData and PutPartialData bursts on channel A; returns AccessAckData or AccessAck on channel D.
- Handles one transaction at a time, with full D-channel backpressure.

Parameters:
- SourceWidth, 4: width of a_source and d_source.
- SinkWidth, 1: width of d_sink (always driven 0).
- BaseAddr, 56'h80000000: byte address of word 0.
- Depth, 4096: number of 64-bit words (power of two).
- MaxSize, 6: largest supported log2 transfer size (64 B, 8 beats).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- host  tl_channel.device  interface (AddrWidth=56, DataWidth=64, SourceWidth)  TileLink link from the socket or host.
- Fields used: a_valid, a_ready, a_opcode[2:0], a_param, a_size, a_source, a_address, a_mask[7:0], a_data[63:0]; d_valid, d_ready, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data.
- Channel ties: b_valid=0, c_ready=1, e_ready=1.

Behaviour:
- Beats per transaction: beats = (size<=3) ? 1 : 2^(size-3). Beat counter is 3 bits.
- Word index = (a_address - BaseAddr) >> 3, aligned down to the size boundary, plus the beat number.
- Range check: address below BaseAddr or word index >= Depth marks the transaction denied. Check is made on the first beat only.
- States: IDLE, READ, WRITE, WACK.
- Reset (async): state=IDLE, d_valid=0, a_ready=0 while rst_ni=0, beat counter=0. RAM contents are not reset.
- IDLE:
  - a_ready=1, d_valid=0.
  - On an A fire, latch source, size, base index and denied.
  - Get -> READ; the RAM read for beat 0 is issued in the same cycle.
  - PutFull/PutPartial -> beat 0 is written in the same cycle (unless denied). 1-beat puts go to WACK; otherwise go to WRITE with counter=1.
- READ:
  - a_ready=0.
  - d_valid rises the cycle after the read is issued, so the earliest response is 1 cycle after the A fire.
  - D signals: d_opcode=AccessAckData(1), d_size=latched size, d_source=latched source, d_param=0, d_sink=0.
  - While d_valid && !d_ready, all D outputs hold stable.
  - On a D fire, the next beat's read is issued and d_valid stays high the following cycle, giving zero bubbles under continuous d_ready.
  - After the final beat fires -> IDLE. a_ready=1 from the next cycle.
- WRITE:
  - a_ready=1, d_valid=0.
  - Each A fire writes a_data under byte mask a_mask at base+counter, then increments the counter.
  - On the last beat -> WACK.
  - Opcode, size and address of later beats are ignored.
- WACK:
  - a_ready=0, d_valid=1, d_opcode=AccessAck(0), single beat, size/source echoed.
  - D fire -> IDLE.
- Denied transactions:
  - No RAM access.
  - Put: all beats are still consumed; AccessAck with d_denied=1.
  - Get: every beat has d_denied=1, d_corrupt=1, d_data=0.
- Unsupported opcodes:
  - Arithmetic(2) and Logical(3): consume beats like a Put; respond with AccessAckData beats, d_denied=1, d_corrupt=1.
  - Intent(5): single-beat HintAck(2), d_denied=1.
- a_size > MaxSize: denied, beat count clamped to 8.
- Sub-word Get (size<3): one beat carrying the full aligned 64-bit word.
- d_corrupt=0 and d_denied=0 for all in-range Get/Put.
- Reset mid-transaction: the transaction is abandoned and no response is produced. Words already written persist.
- A simultaneous A-valid and a pending D beat cannot occur because a_ready=0 in READ and WACK.

Test Plan:
- PutFullData size=3, addr=0x80000010, data=0x1122334455667788, mask=0xFF, source=5 -> one AccessAck, source=5, size=3, denied=0. Then Get size=3 at the same address -> AccessAckData with data 0x1122334455667788, d_valid 1 cycle after the A fire.
- 8-beat PutFull size=6 at 0x80000040 with data i*0x0101010101010101 (i=0..7), then Get size=6 with d_ready held high -> 8 consecutive beats, no bubbles, data in order.
- PutPartialData mask=0x0F, data=0xFFFFFFFFFFFFFFFF onto a word holding 0 -> readback 0x00000000FFFFFFFF.
- Get size=6 with d_ready toggling randomly -> d_data, d_source and d_size stable while stalled; exactly 8 beats delivered; a_ready=0 throughout.
- Get at 0x7FFFFFF8 and Put at BaseAddr+Depth*8 -> denied=1; the Get returns corrupt=1, data=0; the RAM is unchanged (verified by readback).
- Assert rst_ni low during beat 3 of a 64 B Get -> d_valid=0 immediately; after release, a_ready=1 and a new Get returns correct data.
